// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: program memory plus PC sequencer that issues decodable
// 16-bit words to control_unit under a valid/stall handshake.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic [15:0]   instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          illegal
);

  localparam int unsigned WW = 16;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t         state;
  logic [WW-1:0]  mem [0:DEPTH-1];
  logic [WW-1:0]  word;
  logic [3:0]     opcode;
  logic           legal;

  assign word   = mem[pc];
  assign opcode = word[11:8];

  // Status outputs decode straight from the state register, so they add no latency.
  assign busy        = (state == FETCH) || (state == ISSUE);
  assign halted      = (state == HALT);
  assign instr_valid = (state == ISSUE);

  // Decodable opcode filter.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_AND, OP_OR, OP_ADD, OP_SUB: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
  end

  // Program memory write port; dropped while a program is running, survives reset.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem[load_addr] <= load_data;
    end
  end

  // Sequencer: fetch, skip illegal words, issue legal ones, stop on HALT or last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= '0;
      pc          <= '0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc      <= '0;
            illegal <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (opcode == OP_HALT) begin
            state <= HALT;
          end else if (!legal) begin
            illegal <= 1'b1;
            if (pc == LAST_ADDR) begin
              state <= HALT;
            end else begin
              pc <= pc + AW'(1);
            end
          end else begin
            instruction <= word;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            if (pc == LAST_ADDR) begin
              state <= HALT;
            end else begin
              pc    <= pc + AW'(1);
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
